// File: rtl/ps2_key_ctrl_if.sv
// Signal bundle between the PS/2 scan-code decoder, its receiver FIFO and the CPU I/O port.
interface ps2_key_ctrl_if;
  logic       kbd_ready;
  logic [7:0] kbd_data;
  logic       kbd_overflow;
  logic       kbd_rdn;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       ev_ack;
  logic [1:0] held;
  logic       err;
  logic       err_clr;

  modport slave (
    input  kbd_ready, kbd_data, kbd_overflow, ev_ack, err_clr,
    output kbd_rdn, ev_valid, ev_code, ev_ext, ev_break, held, err
  );

  modport master (
    output kbd_ready, kbd_data, kbd_overflow, ev_ack, err_clr,
    input  kbd_rdn, ev_valid, ev_code, ev_ext, ev_break, held, err
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// Folds E0/F0/E1-prefixed PS/2 bytes into key events; one byte per 3 cycles (IDLE/POP/DEC).
// A pending event (ev_valid) stalls further pops until the cycle after ev_ack.
module ps2_key_ctrl #(
  parameter logic [7:0]  KEY0_CODE       = 8'h29,
  parameter logic [7:0]  KEY1_CODE       = 8'h76,
  parameter bit          SUPPRESS_REPEAT = 1'b1,
  parameter int unsigned PAUSE_SKIP      = 7
) (
  input logic           clk,
  input logic           clrn,
  ps2_key_ctrl_if.slave bus
);

  localparam int SKIP_W = (PAUSE_SKIP > 1) ? $clog2(PAUSE_SKIP + 1) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(PAUSE_SKIP);

  typedef enum logic [1:0] {IDLE, POP, DEC} state_t;

  state_t            state_q, state_d;
  logic [7:0]        byte_q, byte_d;
  logic              ext_q, ext_d, brk_q, brk_d;
  logic              ext_e, brk_e;
  logic [SKIP_W-1:0] skip_q, skip_d, skip_e;
  logic [1:0]        held_q, held_d;
  logic              ev_valid_q, ev_valid_d;
  logic [7:0]        ev_code_q, ev_code_d;
  logic              ev_ext_q, ev_ext_d, ev_break_q, ev_break_d;
  logic              rdn_q, err_q;
  logic              drop;

  // Keyboard status/response bytes that never form part of a key sequence.
  function automatic logic is_status(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: is_status = 1'b1;
      default:                                  is_status = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    // Overflow resyncs the stream: the byte in DEC this cycle sees cleared prefixes.
    ext_e      = ext_q & ~bus.kbd_overflow;
    brk_e      = brk_q & ~bus.kbd_overflow;
    skip_e     = bus.kbd_overflow ? '0 : skip_q;
    ext_d      = ext_e;
    brk_d      = brk_e;
    skip_d     = skip_e;
    held_d     = held_q;
    ev_valid_d = ev_valid_q & ~bus.ev_ack;
    ev_code_d  = ev_code_q;
    ev_ext_d   = ev_ext_q;
    ev_break_d = ev_break_q;
    drop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.kbd_ready && !ev_valid_q) begin
          byte_d  = bus.kbd_data;
          state_d = POP;
        end
      end
      POP: state_d = DEC;
      DEC: begin
        state_d = IDLE;
        if (skip_e != '0) begin
          skip_d = skip_e - SKIP_W'(1);
        end else if (byte_q == 8'hE1) begin
          skip_d = SKIP_LOAD;
          ext_d  = 1'b0;
          brk_d  = 1'b0;
        end else if (byte_q == 8'hE0) begin
          ext_d = 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_d = 1'b1;
        end else if (is_status(byte_q)) begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end else begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (!ext_e && byte_q == KEY0_CODE) begin
            drop      = SUPPRESS_REPEAT & ~brk_e & held_q[0];
            held_d[0] = ~brk_e;
          end
          if (!ext_e && byte_q == KEY1_CODE) begin
            drop      = drop | (SUPPRESS_REPEAT & ~brk_e & held_q[1]);
            held_d[1] = ~brk_e;
          end
          // ev_valid is always low here: IDLE refuses to pop while an event is pending.
          if (!drop) begin
            ev_valid_d = 1'b1;
            ev_code_d  = byte_q;
            ev_ext_d   = ext_e;
            ev_break_d = brk_e;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      byte_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skip_q     <= '0;
      held_q     <= '0;
      ev_valid_q <= 1'b0;
      ev_code_q  <= '0;
      ev_ext_q   <= 1'b0;
      ev_break_q <= 1'b0;
      rdn_q      <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      skip_q     <= skip_d;
      held_q     <= held_d;
      ev_valid_q <= ev_valid_d;
      ev_code_q  <= ev_code_d;
      ev_ext_q   <= ev_ext_d;
      ev_break_q <= ev_break_d;
      rdn_q      <= (state_d != POP);
      if (bus.kbd_overflow)
        err_q <= 1'b1;
      else if (bus.err_clr)
        err_q <= 1'b0;
    end
  end

  assign bus.kbd_rdn  = rdn_q;
  assign bus.ev_valid = ev_valid_q;
  assign bus.ev_code  = ev_code_q;
  assign bus.ev_ext   = ev_ext_q;
  assign bus.ev_break = ev_break_q;
  assign bus.held     = held_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: receiver FIFO model, event monitor and a byte-level reference decoder.
module tb_ps2_key_ctrl;

  logic clk = 1'b0;
  logic clrn;
  ps2_key_ctrl_if ifc();

  ps2_key_ctrl #(
    .KEY0_CODE(8'h29), .KEY1_CODE(8'h76), .SUPPRESS_REPEAT(1'b1), .PAUSE_SKIP(7)
  ) dut (
    .clk(clk),
    .clrn(clrn),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Receiver FIFO: pops at the end of every cycle with kbd_rdn low.
  logic [7:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;
  int rdn_double = 0;
  bit rdn_prev_low = 1'b0;
  assign ifc.kbd_ready = (wr_ptr != rd_ptr);
  assign ifc.kbd_data  = fifo_mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (ifc.kbd_rdn === 1'b0) begin
      pops++;
      if (rdn_prev_low) rdn_double++;
      if (rd_ptr != wr_ptr) rd_ptr++;
    end
    rdn_prev_low = (ifc.kbd_rdn === 1'b0);
  end

  logic [9:0] obs_q[$];
  always @(posedge clk) begin
    if (ifc.ev_valid === 1'b1 && ifc.ev_ack === 1'b1)
      obs_q.push_back({ifc.ev_ext, ifc.ev_break, ifc.ev_code});
  end

  // Reference decoder working on whole bytes.
  logic [9:0] exp_q[$];
  logic [9:0] want[$];
  bit         m_ext, m_brk;
  int         m_skip;
  logic [1:0] m_held;

  function automatic logic [9:0] ev(input bit e, input bit b, input logic [7:0] c);
    return {e, b, c};
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int k;
    bit sup;
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      m_skip = 7; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
      m_ext = 0; m_brk = 0;
    end else begin
      k = -1;
      if (!m_ext && b == 8'h29) k = 0;
      if (!m_ext && b == 8'h76) k = 1;
      sup = (k >= 0) && !m_brk && m_held[k];
      if (k >= 0) m_held[k] = !m_brk;
      if (!sup) exp_q.push_back(ev(m_ext, m_brk, b));
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_ptr[5:0]] = b;
    wr_ptr++;
    model_byte(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    m_ext = 0; m_brk = 0; m_skip = 0; m_held = 2'b00;
  endtask

  // Waits until the FIFO is empty and no event is pending for several cycles.
  task automatic drain(input bit rand_ack);
    int streak = 0;
    int n = 0;
    while (streak < 4 && n < 4000) begin
      @(negedge clk);
      n++;
      if (wr_ptr == rd_ptr) ifc.ev_ack = 1'b1;
      else ifc.ev_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wr_ptr == rd_ptr && ifc.ev_valid === 1'b0) streak++;
      else streak = 0;
    end
    checks++;
    if (streak < 4) begin
      failures++;
      $display("FAIL drain_timeout: fifo_left=%0d ev_valid=%b after %0d cycles", wr_ptr - rd_ptr, ifc.ev_valid, n);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (ifc.kbd_rdn !== 1'b1) begin failures++; $display("FAIL reset_rdn: got %b exp 1", ifc.kbd_rdn); end
    checks++; if (ifc.ev_valid !== 1'b0) begin failures++; $display("FAIL reset_ev_valid: got %b exp 0", ifc.ev_valid); end
    checks++; if (ifc.ev_code !== 8'h00) begin failures++; $display("FAIL reset_ev_code: got %h exp 00", ifc.ev_code); end
    checks++; if ({ifc.ev_ext, ifc.ev_break} !== 2'b00) begin failures++; $display("FAIL reset_ext_brk: got %b%b exp 00", ifc.ev_ext, ifc.ev_break); end
    checks++; if (ifc.held !== 2'b00) begin failures++; $display("FAIL reset_held: got %b exp 00", ifc.held); end
    checks++; if (ifc.err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b exp 0", ifc.err); end
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_make_break();
    int ob = obs_q.size();
    int p0 = pops;
    int d0 = rdn_double;
    push_byte(8'h29);
    drain(1'b0);
    checks++; if (ifc.held !== 2'b01) begin failures++; $display("FAIL mb_held_make: got %b exp 01", ifc.held); end
    push_byte(8'hF0); push_byte(8'h29);
    drain(1'b0);
    checks++; if (ifc.held !== 2'b00) begin failures++; $display("FAIL mb_held_break: got %b exp 00", ifc.held); end
    want = '{ev(0, 0, 8'h29), ev(0, 1, 8'h29)};
    checks++; if (obs_q.size() - ob !== want.size()) begin failures++; $display("FAIL mb_count: got %0d exp %0d", obs_q.size() - ob, want.size()); end
    for (int i = 0; i < want.size() && ob + i < obs_q.size(); i++) begin
      checks++; if (obs_q[ob+i] !== want[i]) begin failures++; $display("FAIL mb_event[%0d]: got %h exp %h", i, obs_q[ob+i], want[i]); end
    end
    checks++; if (pops - p0 !== 3) begin failures++; $display("FAIL mb_pops: got %0d exp 3", pops - p0); end
    checks++; if (rdn_double - d0 !== 0) begin failures++; $display("FAIL mb_rdn_width: got %0d double-low cycles exp 0", rdn_double - d0); end
  endtask

  task automatic test_ext_break();
    int ob = obs_q.size();
    int p0 = pops;
    logic [1:0] h0 = ifc.held;
    push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
    drain(1'b0);
    want = '{ev(1, 1, 8'h75)};
    checks++; if (obs_q.size() - ob !== 1) begin failures++; $display("FAIL ext_count: got %0d exp 1", obs_q.size() - ob); end
    if (obs_q.size() > ob) begin
      checks++; if (obs_q[ob] !== want[0]) begin failures++; $display("FAIL ext_event: got %h exp %h", obs_q[ob], want[0]); end
    end
    checks++; if (ifc.held !== h0) begin failures++; $display("FAIL ext_held: got %b exp %b", ifc.held, h0); end
    checks++; if (pops - p0 !== 3) begin failures++; $display("FAIL ext_pops: got %0d exp 3", pops - p0); end
  endtask

  task automatic test_repeat();
    int ob = obs_q.size();
    push_byte(8'h29); push_byte(8'h29); push_byte(8'h29); push_byte(8'hF0); push_byte(8'h29);
    drain(1'b0);
    want = '{ev(0, 0, 8'h29), ev(0, 1, 8'h29)};
    checks++; if (obs_q.size() - ob !== 2) begin failures++; $display("FAIL rep_count: got %0d exp 2", obs_q.size() - ob); end
    for (int i = 0; i < want.size() && ob + i < obs_q.size(); i++) begin
      checks++; if (obs_q[ob+i] !== want[i]) begin failures++; $display("FAIL rep_event[%0d]: got %h exp %h", i, obs_q[ob+i], want[i]); end
    end
  endtask

  task automatic test_pause();
    int ob = obs_q.size();
    push_byte(8'hE1); push_byte(8'h14); push_byte(8'h77); push_byte(8'hE1);
    push_byte(8'hF0); push_byte(8'h14); push_byte(8'hF0); push_byte(8'h77);
    push_byte(8'h1C);
    drain(1'b0);
    checks++; if (obs_q.size() - ob !== 1) begin failures++; $display("FAIL pause_count: got %0d exp 1", obs_q.size() - ob); end
    if (obs_q.size() > ob) begin
      checks++; if (obs_q[ob] !== ev(0, 0, 8'h1C)) begin failures++; $display("FAIL pause_event: got %h exp 01c", obs_q[ob]); end
    end
  endtask

  task automatic test_reset_mid();
    int ob;
    push_byte(8'hE0); push_byte(8'hF0);
    drain(1'b0);
    do_reset();
    ob = obs_q.size();
    push_byte(8'h29);
    drain(1'b0);
    checks++; if (obs_q.size() - ob !== 1) begin failures++; $display("FAIL rstmid_count: got %0d exp 1", obs_q.size() - ob); end
    if (obs_q.size() > ob) begin
      checks++; if (obs_q[ob] !== ev(0, 0, 8'h29)) begin failures++; $display("FAIL rstmid_event: got %h exp 029", obs_q[ob]); end
    end
    checks++; if (ifc.held !== 2'b01) begin failures++; $display("FAIL rstmid_held: got %b exp 01", ifc.held); end
  endtask

  task automatic test_back_to_back();
    int ob = obs_q.size();
    int p0 = pops;
    int lat = 0;
    @(negedge clk);
    ifc.ev_ack = 1'b0;
    push_byte(8'h16); push_byte(8'h1E); push_byte(8'h26); push_byte(8'h25);
    repeat (100) @(negedge clk);
    checks++; if (pops - p0 !== 1) begin failures++; $display("FAIL bp_stall_pops: got %0d exp 1", pops - p0); end
    checks++; if (ifc.ev_valid !== 1'b1 || ifc.ev_code !== 8'h16) begin failures++; $display("FAIL bp_pending: got valid=%b code=%h exp valid=1 code=16", ifc.ev_valid, ifc.ev_code); end
    ifc.ev_ack = 1'b1;
    @(negedge clk);
    ifc.ev_ack = 1'b0;
    for (int i = 1; i <= 4 && lat == 0; i++) begin
      if (i > 1) @(negedge clk);
      if (ifc.kbd_rdn === 1'b0) lat = i;
    end
    checks++; if (lat == 0 || lat > 2) begin failures++; $display("FAIL bp_resume: got pop after %0d cycles (0=none) exp 1..2", lat); end
    drain(1'b0);
    want = '{ev(0, 0, 8'h16), ev(0, 0, 8'h1E), ev(0, 0, 8'h26), ev(0, 0, 8'h25)};
    checks++; if (obs_q.size() - ob !== 4) begin failures++; $display("FAIL bp_count: got %0d exp 4", obs_q.size() - ob); end
    for (int i = 0; i < want.size() && ob + i < obs_q.size(); i++) begin
      checks++; if (obs_q[ob+i] !== want[i]) begin failures++; $display("FAIL bp_event[%0d]: got %h exp %h", i, obs_q[ob+i], want[i]); end
    end
    checks++; if (pops - p0 !== 4) begin failures++; $display("FAIL bp_pops: got %0d exp 4", pops - p0); end
  endtask

  task automatic test_overflow();
    int ob;
    logic [1:0] h0;
    push_byte(8'hE0);
    drain(1'b0);
    h0 = ifc.held;
    ob = obs_q.size();
    ifc.kbd_overflow = 1'b1;
    m_ext = 0; m_brk = 0; m_skip = 0;
    @(negedge clk);
    ifc.kbd_overflow = 1'b0;
    checks++; if (ifc.err !== 1'b1) begin failures++; $display("FAIL ovf_err_set: got %b exp 1", ifc.err); end
    push_byte(8'h74);
    drain(1'b0);
    checks++; if (obs_q.size() - ob !== 1) begin failures++; $display("FAIL ovf_count: got %0d exp 1", obs_q.size() - ob); end
    if (obs_q.size() > ob) begin
      checks++; if (obs_q[ob] !== ev(0, 0, 8'h74)) begin failures++; $display("FAIL ovf_event: got %h exp 074", obs_q[ob]); end
    end
    checks++; if (ifc.held !== h0) begin failures++; $display("FAIL ovf_held: got %b exp %b", ifc.held, h0); end
    checks++; if (ifc.err !== 1'b1) begin failures++; $display("FAIL ovf_err_sticky: got %b exp 1", ifc.err); end
    ifc.err_clr = 1'b1;
    @(negedge clk);
    ifc.err_clr = 1'b0;
    checks++; if (ifc.err !== 1'b0) begin failures++; $display("FAIL ovf_err_clr: got %b exp 0", ifc.err); end
  endtask

  task automatic test_random();
    int ob;
    logic [7:0] b;
    int r;
    for (int batch = 0; batch < 6; batch++) begin
      exp_q.delete();
      ob = obs_q.size();
      for (int j = 0; j < 30; j++) begin
        r = $urandom_range(0, 19);
        if (r < 4) b = 8'h29;
        else if (r < 6) b = 8'h76;
        else if (r < 9) b = 8'hF0;
        else if (r < 11) b = 8'hE0;
        else if (r == 11) b = 8'hE1;
        else if (r == 12) b = 8'hFA;
        else b = 8'($urandom_range(0, 255));
        push_byte(b);
      end
      drain(1'b1);
      checks++; if (obs_q.size() - ob !== exp_q.size()) begin failures++; $display("FAIL rnd_count[%0d]: got %0d exp %0d", batch, obs_q.size() - ob, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++) begin
        checks++; if (obs_q[ob+i] !== exp_q[i]) begin failures++; $display("FAIL rnd_event[%0d.%0d]: got %h exp %h", batch, i, obs_q[ob+i], exp_q[i]); end
      end
      checks++; if (ifc.held !== m_held) begin failures++; $display("FAIL rnd_held[%0d]: got %b exp %b", batch, ifc.held, m_held); end
    end
  endtask

  initial begin
    clrn = 1'b0;
    ifc.kbd_overflow = 1'b0;
    ifc.ev_ack = 1'b1;
    ifc.err_clr = 1'b0;
    m_ext = 0; m_brk = 0; m_skip = 0; m_held = 2'b00;
    test_reset();
    test_make_break();
    test_ext_break();
    test_repeat();
    test_pause();
    test_reset_mid();
    test_back_to_back();
    test_overflow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
